output_layer_seq: RTL and testbench

OUTPUT_LAYER_SEQ -- requirements
Module: output_layer_seq

---
 rtl/nn_pkg.sv | 15 +
 rtl/nn_mac.sv | 33 +++
 rtl/output_layer_seq.sv | 150 +++++++++++++++
 tb/tb_output_layer_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared defaults and FSM encoding for the sequential neural-network layers.
package nn_pkg;

   localparam int N_IN_DEF  = 30;
   localparam int N_OUT_DEF = 10;
   localparam int DW_DEF    = 8;
   localparam int ACC_W_DEF = 22;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nn_mac.sv
// Registered signed multiply-accumulate: load starts a new sum from bias + a*b,
// otherwise the product is added to the running accumulator.
module nn_mac #(
   parameter int DW    = 8,
   parameter int ACC_W = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   input  logic [DW-1:0]    bias,
   output logic [ACC_W-1:0] acc
);

   logic signed [2*DW-1:0] prod;
   logic        [ACC_W-1:0] prod_ext;
   logic        [ACC_W-1:0] bias_ext;

   assign prod     = $signed(a) * $signed(b);
   assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
   assign bias_ext = {{(ACC_W-DW){bias[DW-1]}}, bias};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         acc <= load ? (bias_ext + prod_ext) : (acc + prod_ext);
      end
   end

endmodule

// File: rtl/output_layer_seq.sv
// Sequential output layer: one MAC per cycle over N_OUT neurons, streaming each
// score and reporting the argmax digit. OUTPUT_LAYER_SAT_EN clamps scores to [-128,127].
module output_layer_seq
   import nn_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int N_OUT = N_OUT_DEF,
   parameter int DW    = DW_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [DW*N_IN-1:0]       act_in,
   input  logic [DW*N_OUT*N_IN-1:0] weights_HL,
   input  logic [DW*N_OUT-1:0]      biases_HL,
   output logic                    busy,
   output logic                    score_valid,
   output logic [3:0]              score_idx,
   output logic [ACC_W-1:0]        score,
   output logic                    done,
   output logic [3:0]              digit,
   output logic [ACC_W-1:0]        max_score,
   output logic [1:0]              state_dbg
);

   localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);
   localparam logic [3:0]    I_LAST = 4'(N_OUT - 1);

   state_t                  state;
   logic [JW-1:0]           j;
   logic [3:0]              i;
   logic [DW*N_IN-1:0]      act_q;
   logic                    pend;
   logic [3:0]              pend_idx;
   logic [ACC_W-1:0]        acc;
   logic signed [ACC_W-1:0] fin;
   logic signed [ACC_W-1:0] run_max;
   logic [3:0]              run_idx;
   logic                    take;
   logic                    mac_en;
   logic                    mac_load;
   logic [DW-1:0]           mac_a;
   logic [DW-1:0]           mac_w;
   logic [DW-1:0]           mac_b;

   assign state_dbg = state;
   assign mac_en    = (state == ST_MAC);
   assign mac_load  = (j == '0);
   assign mac_a     = act_q[j*DW +: DW];
   assign mac_w     = weights_HL[(i*N_IN + j)*DW +: DW];
   assign mac_b     = biases_HL[i*DW +: DW];

   nn_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (mac_en),
      .load  (mac_load),
      .a     (mac_a),
      .b     (mac_w),
      .bias  (mac_b),
      .acc   (acc)
   );

   // Final score of the neuron whose last MAC completed on the previous edge.
   always_comb begin
      fin = $signed(acc);
`ifdef OUTPUT_LAYER_SAT_EN
      if ($signed(acc) > $signed(ACC_W'(127)))
         fin = $signed(ACC_W'(127));
      else if ($signed(acc) < $signed(ACC_W'(-128)))
         fin = $signed(ACC_W'(-128));
`endif
   end

   // Strictly greater only, so ties keep the lower index.
   assign take = (pend_idx == 4'd0) || (fin > run_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         j           <= '0;
         i           <= '0;
         act_q       <= '0;
         pend        <= 1'b0;
         pend_idx    <= '0;
         run_max     <= '0;
         run_idx     <= '0;
         busy        <= 1'b0;
         score_valid <= 1'b0;
         score_idx   <= '0;
         score       <= '0;
         done        <= 1'b0;
         digit       <= '0;
         max_score   <= '0;
      end else begin
         score_valid <= 1'b0;
         done        <= 1'b0;
         pend        <= 1'b0;
         if (pend) begin
            score_valid <= 1'b1;
            score_idx   <= pend_idx;
            score       <= fin;
            if (take) begin
               run_max <= fin;
               run_idx <= pend_idx;
            end
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  act_q <= act_in;
                  i     <= '0;
                  j     <= '0;
                  busy  <= 1'b1;
                  state <= ST_MAC;
               end
            end
            ST_MAC: begin
               pend     <= (j == J_LAST);
               pend_idx <= i;
               if (j == J_LAST) begin
                  j <= '0;
                  if (i == I_LAST) begin
                     i     <= '0;
                     state <= ST_DONE;
                  end else begin
                     i <= i + 4'd1;
                  end
               end else begin
                  j <= j + JW'(1);
               end
            end
            ST_DONE: begin
               done      <= 1'b1;
               digit     <= take ? pend_idx : run_idx;
               max_score <= take ? fin : run_max;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_layer_seq.sv
// Directed and random checks of output_layer_seq: score stream, argmax, timing,
// start-while-busy and mid-run reset. Honours OUTPUT_LAYER_SAT_EN like the design.
module tb_output_layer_seq;

   localparam int N_IN  = 30;
   localparam int N_OUT = 10;
   localparam int DW    = 8;
   localparam int ACC_W = 22;

   logic                    clk;
   logic                    rst_n;
   logic                    start;
   logic [DW*N_IN-1:0]       act_in;
   logic [DW*N_OUT*N_IN-1:0] weights_HL;
   logic [DW*N_OUT-1:0]      biases_HL;
   logic                    busy;
   logic                    score_valid;
   logic [3:0]              score_idx;
   logic [ACC_W-1:0]        score;
   logic                    done;
   logic [3:0]              digit;
   logic [ACC_W-1:0]        max_score;
   logic [1:0]              state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_digit;
   logic [31:0] exp_max;

   output_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .act_in      (act_in),
      .weights_HL  (weights_HL),
      .biases_HL   (biases_HL),
      .busy        (busy),
      .score_valid (score_valid),
      .score_idx   (score_idx),
      .score       (score),
      .done        (done),
      .digit       (digit),
      .max_score   (max_score),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   function automatic logic [31:0] sext(input logic [ACC_W-1:0] v);
      return {{(32-ACC_W){v[ACC_W-1]}}, v};
   endfunction

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_busy"},  32'(busy), 0);
      check_val({tag, "_valid"}, 32'(score_valid), 0);
      check_val({tag, "_idx"},   32'(score_idx), 0);
      check_val({tag, "_score"}, sext(score), 0);
      check_val({tag, "_done"},  32'(done), 0);
      check_val({tag, "_digit"}, 32'(digit), 0);
      check_val({tag, "_max"},   sext(max_score), 0);
   endtask

   // Reference model: fills exp_q, exp_digit, exp_max from the current vectors.
   task automatic model_fill();
      int s, best, bi, av, wv;
      exp_q.delete();
      best = 0;
      bi   = 0;
      for (int n = 0; n < N_OUT; n++) begin
         s = $signed(biases_HL[n*DW +: DW]);
         for (int k = 0; k < N_IN; k++) begin
            av = $signed(act_in[k*DW +: DW]);
            wv = $signed(weights_HL[(n*N_IN + k)*DW +: DW]);
            s += av * wv;
         end
`ifdef OUTPUT_LAYER_SAT_EN
         if (s > 127) s = 127;
         if (s < -128) s = -128;
`endif
         exp_q.push_back(s);
         if (n == 0 || s > best) begin
            best = s;
            bi   = n;
         end
      end
      exp_digit = bi;
      exp_max   = best;
   endtask

   // driver: run one classification and score the stream against exp_q
   task automatic run_and_check(input string tag, input int restart_at, input bit scramble);
      int cyc, nvalid, extra;
      bit got_done;
      logic [31:0] e;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (scramble)
         for (int k = 0; k < N_IN; k++) act_in[k*DW +: DW] = 8'($urandom_range(0, 255));
      cyc = 0;
      nvalid = 0;
      got_done = 1'b0;
      while (!got_done && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == restart_at) start = 1'b1;
         if (cyc == restart_at + 1) start = 1'b0;
         if (cyc == 1) check_val({tag, "_busy_run"}, 32'(busy), 1);
         if (score_valid) begin
            if (exp_q.size() == 0) begin
               check_val({tag, "_extra_valid"}, 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_val({tag, "_score"}, sext(score), e);
               check_val({tag, "_score_idx"}, 32'(score_idx), nvalid);
            end
            nvalid++;
         end
         if (done) begin
            got_done = 1'b1;
            check_val({tag, "_done_cycle"}, cyc, 301);
            check_val({tag, "_digit"}, 32'(digit), exp_digit);
            check_val({tag, "_max_score"}, sext(max_score), exp_max);
         end
      end
      if (!got_done) check_val({tag, "_done_timeout"}, 0, 1);
      check_val({tag, "_valid_count"}, nvalid, N_OUT);
      check_val({tag, "_busy_after"}, 32'(busy), 0);
      if (restart_at > 0) begin
         extra = 0;
         for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || score_valid || busy) extra++;
         end
         check_val({tag, "_no_second_run"}, extra, 0);
      end
   endtask

   task automatic set_uniform(input logic [7:0] a, input logic [7:0] w, input logic [7:0] b);
      for (int k = 0; k < N_IN; k++) act_in[k*DW +: DW] = a;
      for (int k = 0; k < N_OUT*N_IN; k++) weights_HL[k*DW +: DW] = w;
      for (int k = 0; k < N_OUT; k++) biases_HL[k*DW +: DW] = b;
   endtask

   task automatic load_vec_bias7();
      set_uniform(8'd1, 8'd0, 8'd0);
      biases_HL[7*DW +: DW] = 8'd5;
      exp_q.delete();
      for (int n = 0; n < N_OUT; n++) exp_q.push_back((n == 7) ? 5 : 0);
      exp_digit = 7;
      exp_max   = 5;
   endtask

   task automatic load_vec_neuron3();
      set_uniform(8'd1, 8'd1, 8'd0);
      for (int k = 0; k < N_IN; k++) weights_HL[(3*N_IN + k)*DW +: DW] = 8'd2;
      exp_q.delete();
      for (int n = 0; n < N_OUT; n++) exp_q.push_back((n == 3) ? 60 : 30);
      exp_digit = 3;
      exp_max   = 60;
   endtask

   initial begin
      int cnt;
      logic [31:0] big;
      rst_n = 1'b0;
      start = 1'b0;
      set_uniform(8'd0, 8'd0, 8'd0);
      #2;
      check_outputs_zero("reset");
      check_val("reset_state", 32'(state_dbg), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      load_vec_bias7();
      run_and_check("bias7", 0, 1'b0);

      load_vec_neuron3();
      run_and_check("neuron3", 0, 1'b0);

`ifdef OUTPUT_LAYER_SAT_EN
      big = -128;
`else
      big = -487808;
`endif
      set_uniform(8'd127, 8'h80, 8'h80);
      exp_q.delete();
      for (int n = 0; n < N_OUT; n++) exp_q.push_back(big);
      exp_digit = 0;
      exp_max   = big;
      run_and_check("fullneg", 0, 1'b0);

      load_vec_neuron3();
      run_and_check("restart", 50, 1'b0);

      // mid-run asynchronous reset
      load_vec_bias7();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 0; c < 120; c++) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 350; c++) begin
         @(posedge clk);
         #1;
         if (done || score_valid || busy) cnt++;
      end
      check_val("post_reset_quiet", cnt, 0);
      load_vec_bias7();
      run_and_check("after_reset", 0, 1'b0);

      for (int r = 0; r < 200; r++) begin
         for (int k = 0; k < N_IN; k++) act_in[k*DW +: DW] = 8'($urandom_range(0, 255));
         for (int k = 0; k < N_OUT*N_IN; k++) weights_HL[k*DW +: DW] = 8'($urandom_range(0, 255));
         for (int k = 0; k < N_OUT; k++) biases_HL[k*DW +: DW] = 8'($urandom_range(0, 255));
         model_fill();
         run_and_check("random", 0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
